// File: rtl/rgmii_link_ctrl.sv
// rtl/rgmii_link_ctrl.sv - MDIO poller/arbiter that derives RGMII link_speed from PHY status
//
// Purpose: periodically reads the PHY status register over MDIO, debounces the
// resolved link/speed, and shares the MDIO bus with host register reads.
// Ports:
//   clk_125, reset           clock, asynchronous active-high reset
//   mdc, mdio_i/o/t          MDIO clock and pad (mdio_t = 1 releases the pad)
//   req_valid/addr/ready     host read request handshake
//   rsp_valid, rsp_data      host read response (data held until next response)
//   link_speed, link_up      debounced link state for the RGMII interface
//   speed_update             one-cycle pulse after link_speed changes
module rgmii_link_ctrl #(
  parameter int unsigned CLK_DIV       = 25,
  parameter logic [4:0]  PHY_ADDR      = 5'h01,
  parameter logic [4:0]  STATUS_REG    = 5'h11,
  parameter int unsigned POLL_INTERVAL = 125000
) (
  input  logic        clk_125,
  input  logic        reset,
  output logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        req_valid,
  input  logic [4:0]  req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [1:0]  link_speed,
  output logic        link_up,
  output logic        speed_update
);

  localparam int unsigned PH_W = $clog2(2 * CLK_DIV);
  localparam int unsigned TM_W = $clog2(POLL_INTERVAL);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(POLL_INTERVAL - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [PH_W-1:0]   r_phase, w_phase_next;
  logic [5:0]        r_bit, w_bit_next;
  logic [4:0]        r_regad, w_regad_next;
  logic [TM_W-1:0]   r_timer;
  logic              r_poll_pend;
  logic              r_last_host;
  logic              r_is_poll;
  logic [15:0]       r_rx;
  logic [15:0]       r_rsp_data;
  logic [1:0]        r_link_speed;
  logic [1:0]        r_speed_d;
  logic              r_link_up;
  logic              r_speed_update;
  logic [1:0]        r_cand;
  logic              r_cand_vld;
  logic              r_mdc, r_mdio_o, r_mdio_t;

  logic              w_grant_poll, w_grant_host, w_req_ready;
  logic              w_timer_exp, w_frame_end, w_drive_next;
  logic [63:0]       w_frame;

  assign w_timer_exp = (r_timer == TM_LAST);
  assign w_frame_end = (r_state == S_FRAME) && (r_bit == 6'd63) && (r_phase == PH_LAST);

  // Read frame, MSB first: preamble, ST=01, OP=10, PHYAD, REGAD, then TA/data (released).
  assign w_frame = {32'hFFFF_FFFF, 4'b0110, PHY_ADDR, w_regad_next, 18'h3FFFF};

  always_ff @(posedge clk_125 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_poll = 1'b0;
    w_grant_host = 1'b0;
    w_req_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // On a tie the requester not served last wins.
        if (r_poll_pend && (!req_valid || r_last_host)) begin
          w_grant_poll = 1'b1;
        end else if (req_valid) begin
          w_grant_host = 1'b1;
          w_req_ready  = 1'b1;
        end
        if (w_grant_poll || w_grant_host) w_state_next = S_FRAME;
      end
      S_FRAME: if (w_frame_end) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_phase_next = r_phase;
    w_bit_next   = r_bit;
    if (w_grant_poll || w_grant_host) begin
      w_phase_next = '0;
      w_bit_next   = '0;
    end else if (r_state == S_FRAME) begin
      if (r_phase == PH_LAST) begin
        w_phase_next = '0;
        w_bit_next   = r_bit + 6'd1;
      end else begin
        w_phase_next = r_phase + PH_W'(1);
      end
    end

    w_regad_next = r_regad;
    if (w_grant_host)      w_regad_next = req_addr;
    else if (w_grant_poll) w_regad_next = STATUS_REG;

    w_drive_next = (w_state_next == S_FRAME) && (w_bit_next < 6'd46);
  end

  always_ff @(posedge clk_125 or posedge reset) begin
    if (reset) begin
      r_phase        <= '0;
      r_bit          <= '0;
      r_regad        <= '0;
      r_timer        <= '0;
      r_poll_pend    <= 1'b0;
      r_last_host    <= 1'b1;
      r_is_poll      <= 1'b0;
      r_rx           <= '0;
      r_rsp_data     <= '0;
      r_link_speed   <= 2'b10;
      r_speed_d      <= 2'b10;
      r_link_up      <= 1'b0;
      r_speed_update <= 1'b0;
      r_cand         <= '0;
      r_cand_vld     <= 1'b0;
      r_mdc          <= 1'b0;
      r_mdio_o       <= 1'b1;
      r_mdio_t       <= 1'b1;
    end else begin
      r_timer <= w_timer_exp ? '0 : r_timer + TM_W'(1);
      // An expiry while a poll is still pending is simply absorbed.
      if (w_grant_poll)     r_poll_pend <= 1'b0;
      else if (w_timer_exp) r_poll_pend <= 1'b1;

      if (w_grant_poll || w_grant_host) begin
        r_last_host <= w_grant_host;
        r_is_poll   <= w_grant_poll;
      end

      r_phase <= w_phase_next;
      r_bit   <= w_bit_next;
      r_regad <= w_regad_next;

      // Outputs registered from next-state values so the pad and MDC are glitch-free.
      r_mdc    <= (w_state_next == S_FRAME) && (w_phase_next >= PH_HIGH);
      r_mdio_t <= !w_drive_next;
      r_mdio_o <= w_drive_next ? w_frame[6'd63 - w_bit_next] : 1'b1;

      // Sample on the cycle MDC rises.
      if ((r_state == S_FRAME) && (r_phase == PH_HIGH) && (r_bit >= 6'd48)) begin
        r_rx <= {r_rx[14:0], mdio_i};
      end

      if (w_frame_end) begin
        if (!r_is_poll) begin
          r_rsp_data <= r_rx;
        end else if (!r_rx[10]) begin
          r_link_up  <= 1'b0;
          r_cand_vld <= 1'b0;
        end else if (r_rx[11] && (r_rx[15:14] != 2'b11)) begin
          // A resolved speed must be seen on two consecutive polls before it is applied.
          if (r_cand_vld && (r_cand == r_rx[15:14])) begin
            r_link_up    <= 1'b1;
            r_link_speed <= r_rx[15:14];
          end else begin
            r_cand     <= r_rx[15:14];
            r_cand_vld <= 1'b1;
          end
        end else begin
          r_cand_vld <= 1'b0;
        end
      end

      r_speed_d      <= r_link_speed;
      r_speed_update <= (r_link_speed != r_speed_d);
    end
  end

  assign req_ready    = w_req_ready && !reset;
  assign rsp_valid    = (r_state == S_DONE) && !r_is_poll;
  assign rsp_data     = r_rsp_data;
  assign link_speed   = r_link_speed;
  assign link_up      = r_link_up;
  assign speed_update = r_speed_update;
  assign mdc          = r_mdc;
  assign mdio_o       = r_mdio_o;
  assign mdio_t       = r_mdio_t;

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// tb/tb_rgmii_link_ctrl.sv - self-checking bench for rgmii_link_ctrl with an MDIO PHY model
module tb_rgmii_link_ctrl;
  localparam int CD  = 2;
  localparam int PI  = 400;
  localparam int LAT = 128 * CD + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdc, mdio_o, mdio_t;
  logic        mdio_i = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_addr = 5'd0;
  logic        req_ready, rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  link_speed;
  logic        link_up, speed_update;

  rgmii_link_ctrl #(
    .CLK_DIV(CD), .PHY_ADDR(5'h01), .STATUS_REG(5'h11), .POLL_INTERVAL(PI)
  ) dut (
    .clk_125(clk), .reset(reset), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_t(mdio_t), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .link_speed(link_speed),
    .link_up(link_up), .speed_update(speed_update)
  );

  always #4 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] phy_reg(input logic [4:0] a);
    return (a == 5'h02) ? 16'h001C : {11'h5A5, a};
  endfunction

  typedef struct {
    logic [15:0] status;
    logic        up;
    logic [1:0]  spd;
    logic        upd;
  } pvec_t;
  typedef struct {
    logic       up;
    logic [1:0] spd;
    logic       upd;
  } pexp_t;
  typedef struct {
    logic [15:0] data;
    int          due;
  } hexp_t;

  logic [15:0] status_q[$];
  pexp_t       exp_q[$];
  hexp_t       host_q[$];

  // PHY model: shifts in the header on MDC rising edges, drives read data after falling edges.
  int          pk = 0;
  logic [45:0] hdr = '0;
  logic [15:0] rd_word = 16'hFFFF;
  logic        is_status = 1'b0;
  int          hdr_cnt = 0;
  int          done_cnt = 0;

  initial forever begin
    @(posedge mdc or posedge reset);
    if (reset) begin
      pk = 0;
    end else begin
      if (pk < 46) begin
        chk("mdio_t_driven", mdio_t, 1'b0);
        hdr = {hdr[44:0], mdio_o};
      end else begin
        chk("mdio_t_released", mdio_t, 1'b1);
      end
      if (pk == 45) begin
        chk("preamble", hdr[45:14], 32'hFFFF_FFFF);
        chk("st_op_phyad", hdr[13:5], 9'b0110_00001);
        hdr_cnt++;
        is_status = (hdr[4:0] == 5'h11);
        if (is_status) rd_word = (status_q.size() > 0) ? status_q.pop_front() : 16'h0000;
        else           rd_word = phy_reg(hdr[4:0]);
      end
      pk = (pk == 63) ? 0 : pk + 1;
    end
  end

  initial forever begin
    @(negedge mdc or posedge reset);
    if (reset) begin
      mdio_i = 1'b1;
    end else begin
      mdio_i = (pk >= 48) ? rd_word[63 - pk] : 1'b1;
      if (pk == 0 && is_status) done_cnt++;
    end
  end

  // Scoreboard side: compares poll outcomes and host responses as the DUT produces them.
  int    seen_done = 0;
  int    upd_pulses = 0;
  logic  upd_pending = 1'b0;
  logic  exp_upd = 1'b0;
  pexp_t pe;
  hexp_t he;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (speed_update) upd_pulses++;
      if (upd_pending) begin
        chk("speed_update_pulse", speed_update, exp_upd);
        upd_pending = 1'b0;
      end
      if (done_cnt != seen_done) begin
        seen_done = done_cnt;
        if (exp_q.size() > 0) begin
          pe = exp_q.pop_front();
          chk("poll_link_up", link_up, pe.up);
          chk("poll_link_speed", link_speed, pe.spd);
          chk("speed_update_not_early", speed_update, 1'b0);
          upd_pending = 1'b1;
          exp_upd = pe.upd;
        end
      end
      if (req_valid && req_ready) host_q.push_back('{phy_reg(req_addr), cyc + LAT});
      if (rsp_valid) begin
        if (host_q.size() > 0) begin
          he = host_q.pop_front();
          chk("rsp_data", rsp_data, he.data);
          chk("rsp_latency", cyc, he.due);
        end else begin
          chk("rsp_unexpected", rsp_valid, 1'b0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  pvec_t pv[12];
  int    t0, t1, n, hc;

  initial begin
    pv[0]  = '{16'hAC00, 1'b0, 2'b10, 1'b0};
    pv[1]  = '{16'hAC00, 1'b1, 2'b10, 1'b0};
    pv[2]  = '{16'h6C00, 1'b1, 2'b10, 1'b0};
    pv[3]  = '{16'h6C00, 1'b1, 2'b01, 1'b1};
    pv[4]  = '{16'h0000, 1'b0, 2'b01, 1'b0};
    pv[5]  = '{16'hEC00, 1'b0, 2'b01, 1'b0};
    pv[6]  = '{16'h2C00, 1'b0, 2'b01, 1'b0};
    pv[7]  = '{16'h2C00, 1'b1, 2'b00, 1'b1};
    pv[8]  = '{16'hAC00, 1'b1, 2'b00, 1'b0};
    pv[9]  = '{16'hA400, 1'b1, 2'b00, 1'b0};
    pv[10] = '{16'hAC00, 1'b1, 2'b00, 1'b0};
    pv[11] = '{16'hAC00, 1'b1, 2'b10, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_mdc", mdc, 1'b0);
    chk("rst_mdio_o", mdio_o, 1'b1);
    chk("rst_mdio_t", mdio_t, 1'b1);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_link_speed", link_speed, 2'b10);
    chk("rst_link_up", link_up, 1'b0);
    chk("rst_speed_update", speed_update, 1'b0);

    for (int i = 0; i < 12; i++) begin
      status_q.push_back(pv[i].status);
      exp_q.push_back('{pv[i].up, pv[i].spd, pv[i].upd});
    end

    @(negedge clk);
    reset = 1'b0;
    t0 = cyc;

    // Poll expiry and a host request land in the same IDLE cycle: poll wins.
    repeat (PI) @(posedge clk);
    #1;
    chk("idle_mdio_t", mdio_t, 1'b1);
    chk("idle_mdc", mdc, 1'b0);
    req_addr = 5'h02;
    req_valid = 1'b1;
    #1;
    chk("tie_poll_wins", req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("poll_start_mdio_t", mdio_t, 1'b0);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 2000);
    chk("host_accepted", req_ready, 1'b1);
    chk("host_accept_cycle", cyc - t0, PI + LAT + 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;

    n = 0;
    while ((exp_q.size() > 0 || host_q.size() > 0 || upd_pending) && n < 14 * PI) begin
      @(negedge clk);
      n++;
    end
    chk("all_polls_done", exp_q.size(), 0);
    chk("all_rsp_done", host_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("speed_update_count", upd_pulses, 3);

    // Reset during bit 40 of a frame.
    n = 0;
    while (!(pk == 41 && mdio_t == 1'b0) && n < 3 * PI) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bit40", pk, 41);
    reset = 1'b1;
    #1;
    chk("midrst_mdio_t", mdio_t, 1'b1);
    chk("midrst_mdc", mdc, 1'b0);
    chk("midrst_mdio_o", mdio_o, 1'b1);
    chk("midrst_link_speed", link_speed, 2'b10);
    chk("midrst_link_up", link_up, 1'b0);
    chk("midrst_rsp_data", rsp_data, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    t1 = cyc;
    hc = hdr_cnt;
    repeat (PI) @(posedge clk);
    #1;
    chk("restart_idle_mdio_t", mdio_t, 1'b1);
    @(posedge clk);
    #1;
    chk("restart_poll_mdio_t", mdio_t, 1'b0);
    n = 0;
    while (hdr_cnt == hc && n < 2 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("restart_full_header", hdr_cnt, hc + 1);
    chk("restart_cycle_base", cyc - t1 > PI, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
